// File: rtl/mem_arbiter.sv
// Dual-requester memory arbiter: independent round-robin read and write ports
// sharing one memory, with read-after-write hazard stalling and a stall counter.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        io_rreq_valid,
    output logic [1:0]        io_rreq_ready,
    input  logic [ADDR_W-1:0] io_rreq0_addr,
    input  logic [ADDR_W-1:0] io_rreq1_addr,
    output logic [1:0]        io_rresp_valid,
    output logic [DATA_W-1:0] io_rresp_data,
    input  logic [1:0]        io_wreq_valid,
    output logic [1:0]        io_wreq_ready,
    input  logic [ADDR_W-1:0] io_wreq0_addr,
    input  logic [ADDR_W-1:0] io_wreq1_addr,
    input  logic [DATA_W-1:0] io_wreq0_data,
    input  logic [DATA_W-1:0] io_wreq1_data,
    output logic [ADDR_W-1:0] io_mem_raddr,
    input  logic [DATA_W-1:0] io_mem_rdata,
    output logic [ADDR_W-1:0] io_mem_waddr,
    output logic [DATA_W-1:0] io_mem_wdata,
    output logic              io_mem_wen,
    output logic [7:0]        io_stall_cnt
);

    logic              rptr_q, rptr_d;
    logic              wptr_q, wptr_d;
    logic [1:0]        rresp_valid_q, rresp_valid_d;
    logic [7:0]        stall_cnt_q, stall_cnt_d;

    logic [1:0]        wgrant, rcand, rgrant;
    logic              wfire, rfire, hazard;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;

    // Pointer names the requester that wins when both are valid.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic ptr);
        logic [1:0] g;
        case (valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_comb begin
        wgrant = rr_pick(io_wreq_valid, wptr_q);
        wfire  = |wgrant;
        waddr  = '0;
        wdata  = '0;
        if (wgrant[0]) begin
            waddr = io_wreq0_addr;
            wdata = io_wreq0_data;
        end else if (wgrant[1]) begin
            waddr = io_wreq1_addr;
            wdata = io_wreq1_data;
        end

        rcand = rr_pick(io_rreq_valid, rptr_q);
        raddr = '0;
        if (rcand[0]) begin
            raddr = io_rreq0_addr;
        end else if (rcand[1]) begin
            raddr = io_rreq1_addr;
        end

        // A read that collides with a same-cycle write is held off one cycle
        // so it observes the written data.
        hazard = wfire && (|rcand) && (raddr == waddr);
        rgrant = hazard ? 2'b00 : rcand;
        rfire  = |rgrant;
    end

    always_comb begin
        wptr_d        = wfire ? wgrant[0] : wptr_q;
        rptr_d        = rfire ? rgrant[0] : rptr_q;
        rresp_valid_d = rgrant;
        stall_cnt_d   = stall_cnt_q;
        if (hazard && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr_q        <= 1'b0;
            wptr_q        <= 1'b0;
            rresp_valid_q <= 2'b00;
            stall_cnt_q   <= '0;
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            rresp_valid_q <= rresp_valid_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign io_rreq_ready  = rgrant;
    assign io_wreq_ready  = wgrant;
    assign io_mem_raddr   = raddr;
    assign io_mem_waddr   = waddr;
    assign io_mem_wdata   = wdata;
    assign io_mem_wen     = wfire;
    assign io_rresp_valid = rresp_valid_q;
    assign io_rresp_data  = io_mem_rdata;
    assign io_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected read
// responses, a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  io_rreq_valid;
    logic [1:0]  io_rreq_ready;
    logic [15:0] io_rreq0_addr, io_rreq1_addr;
    logic [1:0]  io_rresp_valid;
    logic [15:0] io_rresp_data;
    logic [1:0]  io_wreq_valid;
    logic [1:0]  io_wreq_ready;
    logic [15:0] io_wreq0_addr, io_wreq1_addr;
    logic [15:0] io_wreq0_data, io_wreq1_data;
    logic [15:0] io_mem_raddr;
    logic [15:0] io_mem_rdata = 16'h0;
    logic [15:0] io_mem_waddr;
    logic [15:0] io_mem_wdata;
    logic        io_mem_wen;
    logic [7:0]  io_stall_cnt;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_rreq_valid  (io_rreq_valid),
        .io_rreq_ready  (io_rreq_ready),
        .io_rreq0_addr  (io_rreq0_addr),
        .io_rreq1_addr  (io_rreq1_addr),
        .io_rresp_valid (io_rresp_valid),
        .io_rresp_data  (io_rresp_data),
        .io_wreq_valid  (io_wreq_valid),
        .io_wreq_ready  (io_wreq_ready),
        .io_wreq0_addr  (io_wreq0_addr),
        .io_wreq1_addr  (io_wreq1_addr),
        .io_wreq0_data  (io_wreq0_data),
        .io_wreq1_data  (io_wreq1_data),
        .io_mem_raddr   (io_mem_raddr),
        .io_mem_rdata   (io_mem_rdata),
        .io_mem_waddr   (io_mem_waddr),
        .io_mem_wdata   (io_mem_wdata),
        .io_mem_wen     (io_mem_wen),
        .io_stall_cnt   (io_stall_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d;
        int unsigned at;
    } resp_t;
    resp_t exp_q[$];
    resp_t e;

    // Memory model: 1-cycle read latency, preset so mem[a] = a ^ 16'hA5A5.
    logic [15:0] mem [256];
    bit mem_ready = 1'b0;
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
            mem_ready = 1'b1;
        end
        io_mem_rdata <= mem[io_mem_raddr[7:0]];
        if (io_mem_wen) mem[io_mem_waddr[7:0]] = io_mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (io_rresp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("rresp_unexpected", 32'(io_rresp_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rresp_valid", 32'(io_rresp_valid), 32'(e.v));
                chk("rresp_data", 32'(io_rresp_data), 32'(e.d));
                chk("rresp_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic push(input logic [1:0] v, input logic [15:0] d);
        resp_t r;
        r.v  = v;
        r.d  = d;
        r.at = cyc + 1;
        exp_q.push_back(r);
    endtask

    task automatic set_r(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1);
        io_rreq_valid = v;
        io_rreq0_addr = a0;
        io_rreq1_addr = a1;
    endtask

    task automatic set_w(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] d0,
                         input logic [15:0] a1, input logic [15:0] d1);
        io_wreq_valid = v;
        io_wreq0_addr = a0;
        io_wreq0_data = d0;
        io_wreq1_addr = a1;
        io_wreq1_data = d1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_r(2'b11, 16'h0010, 16'h0020);
        set_w(2'b01, 16'h0060, 16'h6666, 16'h0000, 16'h0000);

        // Reset state: registers cleared, combinational paths still live.
        @(negedge clock);
        chk("rst_rresp_valid", 32'(io_rresp_valid), 32'h0);
        chk("rst_stall_cnt", 32'(io_stall_cnt), 32'h0);
        chk("rst_rready", 32'(io_rreq_ready), 32'h1);
        chk("rst_raddr", 32'(io_mem_raddr), 32'h0010);
        chk("rst_wready", 32'(io_wreq_ready), 32'h1);
        chk("rst_waddr", 32'(io_mem_waddr), 32'h0060);
        tick();
        set_w(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        reset = 1'b1;

        // Both reads valid: alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            set_r(2'b11, 16'h0010, 16'h0020);
            @(negedge clock);
            if (i % 2 == 0) begin
                chk("rr_ready", 32'(io_rreq_ready), 32'h1);
                chk("rr_raddr", 32'(io_mem_raddr), 32'h0010);
                push(2'b01, 16'hA5B5);
            end else begin
                chk("rr_ready", 32'(io_rreq_ready), 32'h2);
                chk("rr_raddr", 32'(io_mem_raddr), 32'h0020);
                push(2'b10, 16'hA585);
            end
            tick();
        end
        set_r(2'b00, 16'h0, 16'h0);
        @(negedge clock);
        chk("idle_rready", 32'(io_rreq_ready), 32'h0);
        chk("idle_raddr", 32'(io_mem_raddr), 32'h0);
        chk("idle_wen", 32'(io_mem_wen), 32'h0);
        chk("idle_waddr", 32'(io_mem_waddr), 32'h0);
        chk("idle_wdata", 32'(io_mem_wdata), 32'h0);
        tick();

        // Read-after-write hazard on 0x0005.
        set_w(2'b01, 16'h0005, 16'hBEEF, 16'h0, 16'h0);
        set_r(2'b10, 16'h0, 16'h0005);
        @(negedge clock);
        chk("haz_rready", 32'(io_rreq_ready), 32'h0);
        chk("haz_wready", 32'(io_wreq_ready), 32'h1);
        chk("haz_wen", 32'(io_mem_wen), 32'h1);
        chk("haz_waddr", 32'(io_mem_waddr), 32'h0005);
        chk("haz_wdata", 32'(io_mem_wdata), 32'hBEEF);
        chk("haz_raddr", 32'(io_mem_raddr), 32'h0005);
        chk("haz_stall_before", 32'(io_stall_cnt), 32'h0);
        tick();
        set_w(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clock);
        chk("haz_stall_after", 32'(io_stall_cnt), 32'h1);
        chk("haz_retry_rready", 32'(io_rreq_ready), 32'h2);
        push(2'b10, 16'hBEEF);
        tick();
        set_r(2'b00, 16'h0, 16'h0);

        // Only write requester 1 for three cycles, then pointer must name 0.
        for (int i = 0; i < 3; i++) begin
            set_w(2'b10, 16'h0005, 16'hBEEF, 16'h0030, 16'h1234);
            @(negedge clock);
            chk("w1_wready", 32'(io_wreq_ready), 32'h2);
            chk("w1_wen", 32'(io_mem_wen), 32'h1);
            chk("w1_waddr", 32'(io_mem_waddr), 32'h0030);
            chk("w1_wdata", 32'(io_mem_wdata), 32'h1234);
            tick();
        end
        set_w(2'b11, 16'h0005, 16'hBEEF, 16'h0030, 16'h1234);
        @(negedge clock);
        chk("wptr0_wready", 32'(io_wreq_ready), 32'h1);
        chk("wptr0_waddr", 32'(io_mem_waddr), 32'h0005);
        tick();
        @(negedge clock);
        chk("wptr1_wready", 32'(io_wreq_ready), 32'h2);
        tick();
        set_w(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

        // Read back written data, then both-valid with rptr = 1.
        set_r(2'b01, 16'h0030, 16'h0);
        @(negedge clock);
        chk("rb_rready", 32'(io_rreq_ready), 32'h1);
        push(2'b01, 16'h1234);
        tick();
        set_r(2'b11, 16'h0010, 16'h0020);
        @(negedge clock);
        chk("rptr1_rready", 32'(io_rreq_ready), 32'h2);
        chk("rptr1_raddr", 32'(io_mem_raddr), 32'h0020);
        push(2'b10, 16'hA585);
        tick();

        // Continuous hazard: counter starts at 1 and saturates at 255.
        set_w(2'b01, 16'h0040, 16'h4444, 16'h0, 16'h0);
        set_r(2'b01, 16'h0040, 16'h0);
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (n == 1 || n == 300) chk("sat_rready", 32'(io_rreq_ready), 32'h0);
            if (n == 254) chk("sat_cnt_254", 32'(io_stall_cnt), 32'd254);
            if (n == 255) chk("sat_cnt_255", 32'(io_stall_cnt), 32'd255);
            if (n == 256) chk("sat_cnt_hold", 32'(io_stall_cnt), 32'd255);
            tick();
        end
        set_w(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clock);
        chk("sat_cnt_final", 32'(io_stall_cnt), 32'd255);
        chk("sat_retry_rready", 32'(io_rreq_ready), 32'h1);
        push(2'b01, 16'h4444);
        tick();

        // Read fires, then reset drops the in-flight response.
        set_r(2'b01, 16'h0010, 16'h0);
        @(negedge clock);
        chk("rst_fire_rready", 32'(io_rreq_ready), 32'h1);
        tick();
        set_r(2'b00, 16'h0, 16'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_drop_rresp", 32'(io_rresp_valid), 32'h0);
        chk("rst_drop_stall", 32'(io_stall_cnt), 32'h0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_rresp", 32'(io_rresp_valid), 32'h0);
        set_r(2'b11, 16'h0010, 16'h0020);
        set_w(2'b11, 16'h0050, 16'h5555, 16'h0060, 16'h6666);
        #1;
        chk("post_rst_rptr", 32'(io_rreq_ready), 32'h1);
        chk("post_rst_wptr", 32'(io_wreq_ready), 32'h1);
        push(2'b01, 16'hA5B5);
        tick();
        set_r(2'b00, 16'h0, 16'h0);
        set_w(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) tick();
        @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
